// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared types and widths for the accelerator memory path
package accel_pkg;

  localparam int VECTOR_WIDTH = 32;

  typedef enum logic [1:0] {
    ZERO = 2'b00,
    POS  = 2'b01,
    NEG  = 2'b10,
    RSVD = 2'b11
  } mat_code_t;

  typedef enum logic [1:0] {
    MEM_OK        = 2'b00,
    MEM_ERR_RANGE = 2'b01,
    MEM_ERR_CODE  = 2'b10,
    MEM_ERR_BUSY  = 2'b11
  } mem_error_t;

  typedef enum logic [1:0] {
    ST_INIT    = 2'b00,
    ST_READY   = 2'b01,
    ST_RECOVER = 2'b10
  } bank_state_t;

endpackage

// File: rtl/shared_mem_array.sv
// rtl/shared_mem_array.sv - width/depth array, synchronous write, asynchronous read
module shared_mem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic waddr_ok;
  logic raddr_ok;

  assign waddr_ok = int'(waddr) < DEPTH;
  assign raddr_ok = int'(raddr) < DEPTH;

  // Contents are deliberately not reset; the owner clears them by sweeping.
  always_ff @(posedge clk) begin
    if (we && waddr_ok) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  assign rdata = raddr_ok ? mem[raddr[IW-1:0]] : '0;

endmodule

// File: rtl/shared_memory_bank.sv
// rtl/shared_memory_bank.sv - dual-port vector/matrix store with init sweep, write recovery and error pulses
module shared_memory_bank
  import accel_pkg::*;
#(
  parameter int VEC_DEPTH      = 64,
  parameter int MAT_DEPTH      = 256,
  parameter int WRITE_RECOVERY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5:0]              mem_addr_a,
  input  logic                    mem_we_a,
  input  logic [VECTOR_WIDTH-1:0] mem_wdata_a,
  output logic [VECTOR_WIDTH-1:0] mem_rdata_a,
  input  logic [7:0]              mem_addr_b,
  input  logic                    mem_we_b,
  input  logic [1:0]              mem_wdata_b,
  output logic [1:0]              mem_rdata_b,
  output logic                    mem_busy,
  output logic [1:0]              mem_error
);

  bank_state_t state, state_n;
  logic [7:0]  clr_idx, clr_idx_n;
  logic [2:0]  rec_cnt, rec_cnt_n;
  logic        busy_n;
  mem_error_t  err_q, err_n;

  logic legal_a, legal_b, code_rsvd;
  logic acc_a, acc_b;
  logic in_init;

  logic                    a_we, b_we;
  logic [5:0]              a_waddr;
  logic [7:0]              b_waddr;
  logic [VECTOR_WIDTH-1:0] a_wdata, a_rdata;
  logic [1:0]              b_wdata, b_rdata;

  assign in_init   = (state == ST_INIT);
  assign legal_a   = int'(mem_addr_a) < VEC_DEPTH;
  assign legal_b   = int'(mem_addr_b) < MAT_DEPTH;
  assign code_rsvd = (mat_code_t'(mem_wdata_b) == RSVD);
  assign acc_a     = !mem_busy && mem_we_a && legal_a;
  assign acc_b     = !mem_busy && mem_we_b && legal_b && !code_rsvd;

  // The clear sweep owns both write ports while in INIT.
  assign a_we    = in_init ? (int'(clr_idx) < VEC_DEPTH) : acc_a;
  assign a_waddr = in_init ? clr_idx[5:0] : mem_addr_a;
  assign a_wdata = in_init ? '0 : mem_wdata_a;
  assign b_we    = in_init ? 1'b1 : acc_b;
  assign b_waddr = in_init ? clr_idx : mem_addr_b;
  assign b_wdata = in_init ? 2'b00 : mem_wdata_b;

  shared_mem_array #(.WIDTH(VECTOR_WIDTH), .DEPTH(VEC_DEPTH), .AW(6)) u_vec (
    .clk   (clk),
    .we    (a_we),
    .waddr (a_waddr),
    .wdata (a_wdata),
    .raddr (mem_addr_a),
    .rdata (a_rdata)
  );

  shared_mem_array #(.WIDTH(2), .DEPTH(MAT_DEPTH), .AW(8)) u_mat (
    .clk   (clk),
    .we    (b_we),
    .waddr (b_waddr),
    .wdata (b_wdata),
    .raddr (mem_addr_b),
    .rdata (b_rdata)
  );

  assign mem_rdata_a = in_init ? '0 : a_rdata;
  assign mem_rdata_b = in_init ? 2'b00 : b_rdata;
  assign mem_error   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      clr_idx  <= '0;
      rec_cnt  <= '0;
      mem_busy <= 1'b1;
      err_q    <= MEM_OK;
    end else begin
      state    <= state_n;
      clr_idx  <= clr_idx_n;
      rec_cnt  <= rec_cnt_n;
      mem_busy <= busy_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    clr_idx_n = clr_idx;
    rec_cnt_n = rec_cnt;
    err_n     = MEM_OK;

    case (state)
      ST_INIT: begin
        clr_idx_n = clr_idx + 8'd1;
        if (int'(clr_idx) == MAT_DEPTH - 1) begin
          state_n   = ST_READY;
          clr_idx_n = '0;
        end
      end
      ST_READY: begin
        if ((acc_a || acc_b) && (WRITE_RECOVERY > 0)) begin
          state_n   = ST_RECOVER;
          rec_cnt_n = 3'(WRITE_RECOVERY);
        end
      end
      ST_RECOVER: begin
        rec_cnt_n = rec_cnt - 3'd1;
        if (rec_cnt <= 3'd1) begin
          state_n   = ST_READY;
          rec_cnt_n = '0;
        end
      end
      default: state_n = ST_INIT;
    endcase

    busy_n = (state_n != ST_READY);

    // Busy outranks range, which outranks a reserved code.
    if (mem_busy && (mem_we_a || mem_we_b)) begin
      err_n = MEM_ERR_BUSY;
    end else if ((mem_we_a && !legal_a) || (mem_we_b && !legal_b)) begin
      err_n = MEM_ERR_RANGE;
    end else if (mem_we_b && code_rsvd) begin
      err_n = MEM_ERR_CODE;
    end
  end

endmodule

// File: doc/shared_memory_bank.md
# shared_memory_bank

Dual-port on-chip store behind `memory_controller`, directly downstream of it. Port A holds activation vectors, `VEC_DEPTH` words of `VECTOR_WIDTH` bits. Port B holds ternary matrix weights, `MAT_DEPTH` entries of 2 bits. The block clears itself after reset, throttles the controller through `mem_busy` during init and write recovery, and reports illegal accesses as one-cycle codes on `mem_error`.

## Interface
Parameters:
- `VEC_DEPTH`, 64: port A words; legal addresses 0..VEC_DEPTH-1, maximum 64.
- `MAT_DEPTH`, 256: port B entries; legal addresses 0..MAT_DEPTH-1, maximum 256.
- `WRITE_RECOVERY`, 1: busy cycles after an accepted write; range 0..7.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous active-low reset.
- `mem_addr_a` in 6: vector address.
- `mem_we_a` in 1: vector write enable.
- `mem_wdata_a` in `VECTOR_WIDTH`: vector write data.
- `mem_rdata_a` out `VECTOR_WIDTH`: vector read data.
- `mem_addr_b` in 8: matrix address.
- `mem_we_b` in 1: matrix write enable.
- `mem_wdata_b` in 2: matrix code; 00 = 0, 01 = +1, 10 = -1, 11 = reserved.
- `mem_rdata_b` out 2: matrix read data.
- `mem_busy` out 1: writes are not accepted while high.
- `mem_error` out 2: error code, valid for a single cycle.

## Operation
- FSM states:
  - INIT: clear sweep.
  - READY: accepts writes.
  - RECOVER: busy countdown.
- Reset forces INIT immediately, at any time, including mid-write:
  - Internal counters clear.
  - Outputs go to `mem_busy`=1, `mem_error`=00, `mem_rdata_a`=0, `mem_rdata_b`=00.
  - Array contents are not reset directly; the INIT sweep clears them.
- INIT sweep:
  - 8-bit `clr_idx` increments every cycle.
  - Each cycle writes 0 to B[clr_idx]; also writes 0 to A[clr_idx] when `clr_idx` < VEC_DEPTH.
  - Leaves INIT for READY after `clr_idx` = MAT_DEPTH-1.
  - Both read ports return 0 throughout INIT.
- Reads:
  - Asynchronous (combinational) from address in READY and RECOVER.
  - An out-of-range read address returns 0 and raises no error.
- Write acceptance: a write is accepted only when `mem_busy`=0 and the address is legal. For port B the code must also not be 11.
- Accepted write:
  - Array updates at the clock edge.
  - A read of the same address in the same cycle returns the old data.
  - If WRITE_RECOVERY>0, go to RECOVER with countdown = WRITE_RECOVERY.
  - If WRITE_RECOVERY=0, stay in READY.
- Both ports writing in the same cycle: both writes are accepted and share a single recovery window.
- RECOVER: `mem_busy`=1 and the countdown decrements each cycle; at 1, return to READY.
- Rejected write: array unchanged, no state change.
- Error codes are registered and pulse for one cycle:
  - 01: write address out of range on either port.
  - 10: port B write with code 11.
  - 11: write attempted while `mem_busy`=1 (INIT or RECOVER).
- Priority when several errors occur in one cycle: 11 > 01 > 10.
- `mem_error` returns to 00 the next cycle unless a new violation occurs. It is never sticky, so the controller's ERROR_HANDLE→IDLE path terminates.

## Timing
- Init duration: `mem_busy` is high from reset assertion through MAT_DEPTH rising edges after `rst_n` rises. It is low from the cycle after the edge that cleared entry MAT_DEPTH-1.
- Read latency: 0 cycles; data is valid in the same cycle as the address.
- Write recovery:
  - Write accepted at edge E.
  - `mem_busy` is high for cycles E+1 through E+WRITE_RECOVERY.
  - The next write is accepted at edge E+WRITE_RECOVERY+1.
- Error latency: violation sampled at edge E → `mem_error` valid for the cycle after E.
- `mem_busy`, `mem_error` and the FSM state are registered outputs; the read data outputs are combinational.

## Structure
- `accel_pkg` holds:
  - `VECTOR_WIDTH`.
  - `mat_code_t` (2-bit enum: ZERO, POS, NEG, RSVD).
  - `mem_error_t` (MEM_OK=00, MEM_ERR_RANGE=01, MEM_ERR_CODE=10, MEM_ERR_BUSY=11).
- Sub-module `shared_mem_array`: parameterised width/depth array with synchronous write and asynchronous read. It is instantiated twice, for ports A and B.
- The top level holds the FSM, the clear sweep mux, the recovery counter and the error encoder.

## Test plan
- Reset, then idle → `mem_busy`=1 for exactly 256 cycles, then 0; reads of A[63] and B[255] return 0.
- After init, write A[5]=0xA5A5… then read A[5] → same cycle returns old value 0, next cycle returns new value; `mem_busy`=1 for one cycle only.
- Write B[17]=11 → `mem_error`=10 for one cycle; read B[17] still returns 00.
- With VEC_DEPTH=32, write A[40] while a write during RECOVER occurs on port B → `mem_error`=11 (priority); neither array changes.
- Simultaneous accepted writes A[3] and B[3]=01 → both visible; single busy cycle; `mem_error`=00.
- Pulse `rst_n` low mid-RECOVER after writing A[2] → `mem_busy`=1 immediately; after the 256-cycle sweep, A[2] reads 0.
